// File: rtl/readout_sched_pkg.sv
// Shared types and constants for the two-channel ADC readout scheduler.
package readout_sched_pkg;

  localparam logic [3:0]  SYNC_TAG_DEF   = 4'hA;
  localparam logic [11:0] PAD_SAMPLE_DEF = 12'hFFF;
  localparam int          LEN_MSB        = 9;

  typedef enum logic [3:0] {
    ST_IDLE, ST_HPOP, ST_HLAT, ST_TAG, ST_HLO, ST_HHI,
    ST_FETCH, ST_S0RD, ST_S0LAT, ST_S1RD, ST_S1LAT,
    ST_B0, ST_B1, ST_B2, ST_DONE
  } state_t;

  typedef enum logic {SEND_WAIT, SEND_GAP} send_t;

  // Byte sequencing: B2 only exists when a second sample was taken.
  function automatic state_t after_byte(state_t st, logic two);
    case (st)
      ST_TAG:  return ST_HLO;
      ST_HLO:  return ST_HHI;
      ST_B0:   return ST_B1;
      ST_B1:   return two ? ST_B2 : ST_FETCH;
      default: return ST_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/readout_sched_rr_arb2.sv
// Two-requester round-robin arbiter; remembers the last served channel.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_ch,
  output logic [1:0] gnt
);

  logic last;

  // last starts at 1 so channel 0 wins the first tie
  always_ff @(posedge clk) begin
    if (reset)    last <= 1'b1;
    else if (upd) last <= upd_ch;
  end

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/readout_sched.sv
// Serializes header/sample frames from two ADC channels onto a single UART TX.
//  state  | meaning
//  IDLE   | wait for en and a pending header, grant a channel
//  HPOP   | header pop strobe active
//  HLAT   | header word valid, latch it and the sample count
//  TAG    | send {SYNC_TAG,000,ch}
//  HLO    | send header[7:0]
//  HHI    | send header[15:8]
//  FETCH  | frame done if no samples left, else pop first sample
//  S0RD   | first sample pop strobe active
//  S0LAT  | latch first sample, pop second one if the pair is complete
//  S1RD   | second sample pop strobe active
//  S1LAT  | latch second sample
//  B0..B2 | send packed sample bytes
//  DONE   | count frame, release the bus
module readout_sched
  import readout_sched_pkg::*;
#(
  parameter logic [3:0]  SYNC_TAG   = SYNC_TAG_DEF,
  parameter logic [11:0] PAD_SAMPLE = PAD_SAMPLE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [7:0]  ch0_hdr_lvl,
  input  logic [15:0] ch0_hdr_data,
  output logic        ch0_hdr_rd,
  input  logic [9:0]  ch0_dat_lvl,
  input  logic [11:0] ch0_dat_data,
  output logic        ch0_dat_rd,
  input  logic [7:0]  ch1_hdr_lvl,
  input  logic [15:0] ch1_hdr_data,
  output logic        ch1_hdr_rd,
  input  logic [9:0]  ch1_dat_lvl,
  input  logic [11:0] ch1_dat_data,
  output logic        ch1_dat_rd,
  output logic [7:0]  tx_byte,
  output logic        tx_load,
  input  logic        tx_ready,
  output logic        busy,
  output logic        cur_ch,
  output logic        underrun,
  output logic [15:0] frame_cnt
);

  state_t      state;
  send_t       send;
  logic [15:0] hdr_reg;
  logic [9:0]  rem;
  logic [11:0] s0, s1;
  logic        pair, pad;
  logic [1:0]  gnt;
  logic [15:0] hdr_data;
  logic [9:0]  dat_lvl;
  logic [11:0] dat_data;

  assign hdr_data = cur_ch ? ch1_hdr_data : ch0_hdr_data;
  assign dat_lvl  = cur_ch ? ch1_dat_lvl  : ch0_dat_lvl;
  assign dat_data = cur_ch ? ch1_dat_data : ch0_dat_data;

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({ch1_hdr_lvl != 8'd0, ch0_hdr_lvl != 8'd0}),
    .upd    (state == ST_DONE),
    .upd_ch (cur_ch),
    .gnt    (gnt)
  );

  function automatic logic [7:0] frame_byte(state_t st, logic ch, logic [15:0] hdr,
                                            logic [11:0] a, logic [11:0] b, logic two);
    case (st)
      ST_TAG:  return {SYNC_TAG, 3'b000, ch};
      ST_HLO:  return hdr[7:0];
      ST_HHI:  return hdr[15:8];
      ST_B0:   return a[7:0];
      ST_B1:   return two ? {b[3:0], a[11:8]} : {4'h0, a[11:8]};
      ST_B2:   return b[11:4];
      default: return 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      send       <= SEND_WAIT;
      hdr_reg    <= '0;
      rem        <= '0;
      s0         <= '0;
      s1         <= '0;
      pair       <= 1'b0;
      pad        <= 1'b0;
      ch0_hdr_rd <= 1'b0;
      ch1_hdr_rd <= 1'b0;
      ch0_dat_rd <= 1'b0;
      ch1_dat_rd <= 1'b0;
      tx_byte    <= '0;
      tx_load    <= 1'b0;
      busy       <= 1'b0;
      cur_ch     <= 1'b0;
      underrun   <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      ch0_hdr_rd <= 1'b0;
      ch1_hdr_rd <= 1'b0;
      ch0_dat_rd <= 1'b0;
      ch1_dat_rd <= 1'b0;
      tx_load    <= 1'b0;
      case (state)
        ST_IDLE: if (en && gnt != 2'b00) begin
          cur_ch     <= gnt[1];
          busy       <= 1'b1;
          ch0_hdr_rd <= gnt[0];
          ch1_hdr_rd <= gnt[1];
          state      <= ST_HPOP;
        end
        ST_HPOP: state <= ST_HLAT;
        ST_HLAT: begin
          hdr_reg <= hdr_data;
          rem     <= hdr_data[LEN_MSB:0];
          state   <= ST_TAG;
        end
        ST_TAG, ST_HLO, ST_HHI, ST_B0, ST_B1, ST_B2: begin
          // every load is followed by one cycle where tx_ready is ignored
          if (send == SEND_WAIT) begin
            if (tx_ready) begin
              tx_byte <= frame_byte(state, cur_ch, hdr_reg, s0, s1, pair);
              tx_load <= 1'b1;
              send    <= SEND_GAP;
            end
          end else begin
            send  <= SEND_WAIT;
            state <= after_byte(state, pair);
          end
        end
        ST_FETCH: begin
          if (rem == 10'd0) begin
            state <= ST_DONE;
          end else begin
            pair       <= (rem >= 10'd2);
            pad        <= (dat_lvl == 10'd0);
            ch0_dat_rd <= !cur_ch && dat_lvl != 10'd0;
            ch1_dat_rd <= cur_ch && dat_lvl != 10'd0;
            rem        <= rem - 10'd1;
            state      <= ST_S0RD;
          end
        end
        ST_S0RD: state <= ST_S0LAT;
        ST_S0LAT: begin
          s0 <= pad ? PAD_SAMPLE : dat_data;
          if (pad) underrun <= 1'b1;
          if (pair) begin
            pad        <= (dat_lvl == 10'd0);
            ch0_dat_rd <= !cur_ch && dat_lvl != 10'd0;
            ch1_dat_rd <= cur_ch && dat_lvl != 10'd0;
            rem        <= rem - 10'd1;
            state      <= ST_S1RD;
          end else begin
            state <= ST_B0;
          end
        end
        ST_S1RD: state <= ST_S1LAT;
        ST_S1LAT: begin
          s1 <= pad ? PAD_SAMPLE : dat_data;
          if (pad) underrun <= 1'b1;
          state <= ST_B0;
        end
        ST_DONE: begin
          frame_cnt <= frame_cnt + 16'd1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_readout_sched.sv
// Directed bench for readout_sched: FIFO models, UART byte capture, expected frames.
module tb_readout_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b1;
  logic [7:0]  ch0_hdr_lvl = '0, ch1_hdr_lvl = '0;
  logic [15:0] ch0_hdr_data = '0, ch1_hdr_data = '0;
  logic [9:0]  ch0_dat_lvl = '0, ch1_dat_lvl = '0;
  logic [11:0] ch0_dat_data = '0, ch1_dat_data = '0;
  logic        ch0_hdr_rd, ch1_hdr_rd, ch0_dat_rd, ch1_dat_rd;
  logic [7:0]  tx_byte;
  logic        tx_load;
  logic        tx_ready = 1'b1;
  logic        busy, cur_ch, underrun;
  logic [15:0] frame_cnt;

  int n_checks = 0;
  int n_fail = 0;

  logic [15:0] hq0[$], hq1[$];
  logic [11:0] dq0[$], dq1[$];
  logic [7:0]  rx[$];
  logic [7:0]  exp_q[$];
  logic [11:0] smp[$];
  int          n_rd0 = 0, n_rd1 = 0;

  always #8 clk = ~clk;

  readout_sched dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .ch0_hdr_lvl  (ch0_hdr_lvl),
    .ch0_hdr_data (ch0_hdr_data),
    .ch0_hdr_rd   (ch0_hdr_rd),
    .ch0_dat_lvl  (ch0_dat_lvl),
    .ch0_dat_data (ch0_dat_data),
    .ch0_dat_rd   (ch0_dat_rd),
    .ch1_hdr_lvl  (ch1_hdr_lvl),
    .ch1_hdr_data (ch1_hdr_data),
    .ch1_hdr_rd   (ch1_hdr_rd),
    .ch1_dat_lvl  (ch1_dat_lvl),
    .ch1_dat_data (ch1_dat_data),
    .ch1_dat_rd   (ch1_dat_rd),
    .tx_byte      (tx_byte),
    .tx_load      (tx_load),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .cur_ch       (cur_ch),
    .underrun     (underrun),
    .frame_cnt    (frame_cnt)
  );

  // FIFO models: data appears the cycle after a pop, levels are registered
  always @(posedge clk) begin
    if (ch0_hdr_rd && hq0.size() != 0) ch0_hdr_data <= hq0.pop_front();
    if (ch1_hdr_rd && hq1.size() != 0) ch1_hdr_data <= hq1.pop_front();
    if (ch0_dat_rd) begin
      n_rd0 <= n_rd0 + 1;
      if (dq0.size() != 0) ch0_dat_data <= dq0.pop_front();
    end
    if (ch1_dat_rd) begin
      n_rd1 <= n_rd1 + 1;
      if (dq1.size() != 0) ch1_dat_data <= dq1.pop_front();
    end
    ch0_hdr_lvl <= 8'(hq0.size());
    ch1_hdr_lvl <= 8'(hq1.size());
    ch0_dat_lvl <= 10'(dq0.size());
    ch1_dat_lvl <= 10'(dq1.size());
  end

  always @(negedge clk) begin
    if (tx_load) rx.push_back(tx_byte);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_frames(input string tag, input logic [15:0] target, input int budget);
    int n = 0;
    while (frame_cnt != target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(frame_cnt), 32'(target));
  endtask

  task automatic check_frame(input string tag, input int base);
    check({tag, "_nbytes"}, 32'(rx.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [7:0] g;
      g = (base + i < rx.size()) ? rx[base + i] : 8'h00;
      check($sformatf("%s_b%0d", tag, i), 32'(g), 32'(exp_q[i]));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int base, rd_base, mis;
    logic [11:0] a, b;

    do_reset();
    check("rst_busy", 32'(busy), 0);
    check("rst_tx_byte", 32'(tx_byte), 0);
    check("rst_tx_load", 32'(tx_load), 0);
    check("rst_cur_ch", 32'(cur_ch), 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);

    // 1: three samples on ch0
    base = rx.size();
    rd_base = n_rd0;
    hq0.push_back(16'h0403);
    dq0.push_back(12'h123); dq0.push_back(12'h456); dq0.push_back(12'h789);
    wait_frames("t1_done", 16'd1, 500);
    exp_q = {8'hA0, 8'h03, 8'h04, 8'h23, 8'h61, 8'h45, 8'h89, 8'h07};
    check_frame("t1", base);
    check("t1_dat_rd", 32'(n_rd0 - rd_base), 3);
    check("t1_busy", 32'(busy), 0);
    check("t1_underrun", 32'(underrun), 0);

    // 2: round robin with both channels pending, header-only frames
    en = 1'b0;
    do_reset();
    hq0.push_back(16'h0400); hq0.push_back(16'h0800);
    hq1.push_back(16'h0C00); hq1.push_back(16'h1000);
    repeat (2) @(negedge clk);
    base = rx.size();
    en = 1'b1;
    wait_frames("t2_done", 16'd4, 500);
    exp_q = {8'hA0, 8'h00, 8'h04, 8'hA1, 8'h00, 8'h0C,
             8'hA0, 8'h00, 8'h08, 8'hA1, 8'h00, 8'h10};
    check_frame("t2", base);
    check("t2_cur_ch", 32'(cur_ch), 1);

    // 3: ch1 underrun, both samples padded
    base = rx.size();
    rd_base = n_rd1;
    hq1.push_back(16'h0002);
    wait_frames("t3_done", 16'd5, 500);
    exp_q = {8'hA1, 8'h02, 8'h00, 8'hFF, 8'hFF, 8'hFF};
    check_frame("t3", base);
    check("t3_no_dat_rd", 32'(n_rd1 - rd_base), 0);
    check("t3_underrun", 32'(underrun), 1);

    // 4: tx_ready stalls after the first sample byte
    base = rx.size();
    hq0.push_back(16'h0002);
    dq0.push_back(12'hABC); dq0.push_back(12'hDEF);
    for (int n = 0; n < 500 && rx.size() < base + 4; n++) @(negedge clk);
    tx_ready = 1'b0;
    repeat (50) @(negedge clk);
    check("t4_stall_loads", 32'(rx.size() - base), 4);
    check("t4_stall_byte", 32'(tx_byte), 32'h0BC);
    check("t4_stall_busy", 32'(busy), 1);
    tx_ready = 1'b1;
    wait_frames("t4_done", 16'd6, 500);
    exp_q = {8'hA0, 8'h02, 8'h00, 8'hBC, 8'hFA, 8'hDE};
    check_frame("t4", base);
    check("t4_underrun_sticky", 32'(underrun), 1);

    // 5: reset in the middle of B1, pending headers resume after release
    base = rx.size();
    hq0.push_back(16'h0002); hq0.push_back(16'h1400);
    dq0.push_back(12'h111); dq0.push_back(12'h222);
    for (int n = 0; n < 500 && !busy; n++) @(negedge clk);
    hq1.push_back(16'h1800);
    for (int n = 0; n < 500 && rx.size() < base + 4; n++) @(negedge clk);
    tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_tx_byte", 32'(tx_byte), 0);
    check("t5_rst_tx_load", 32'(tx_load), 0);
    check("t5_rst_underrun", 32'(underrun), 0);
    check("t5_rst_frame_cnt", 32'(frame_cnt), 0);
    reset = 1'b0;
    tx_ready = 1'b1;
    base = rx.size();
    wait_frames("t5_done", 16'd2, 500);
    exp_q = {8'hA0, 8'h00, 8'h14, 8'hA1, 8'h00, 8'h18};
    check_frame("t5", base);

    // 6: maximum length frame
    base = rx.size();
    rd_base = n_rd0;
    smp.delete();
    for (int i = 0; i < 1023; i++) begin
      smp.push_back(12'((i * 37 + 5) % 4096));
      dq0.push_back(12'((i * 37 + 5) % 4096));
    end
    exp_q = {8'hA0, 8'hFF, 8'h03};
    for (int i = 0; i + 1 < 1023; i += 2) begin
      a = smp[i];
      b = smp[i + 1];
      exp_q.push_back(a[7:0]);
      exp_q.push_back({b[3:0], a[11:8]});
      exp_q.push_back(b[11:4]);
    end
    a = smp[1022];
    exp_q.push_back(a[7:0]);
    exp_q.push_back({4'h0, a[11:8]});
    hq0.push_back(16'h03FF);
    wait_frames("t6_done", 16'd3, 20000);
    check("t6_nbytes", 32'(rx.size() - base), 1538);
    check("t6_dat_rd", 32'(n_rd0 - rd_base), 1023);
    mis = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i >= rx.size() || rx[base + i] !== exp_q[i]) mis++;
    check("t6_byte_mismatches", 32'(mis), 0);
    check("t6_last_lo", 32'(rx[rx.size() - 2]), 32'({24'h0, a[7:0]}));
    check("t6_last_hi", 32'(rx[rx.size() - 1]), 32'({28'h0, a[11:8]}));
    check("t6_busy", 32'(busy), 0);
    check("t6_underrun", 32'(underrun), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
